enable_sequence_checker: RTL and testbench

// - Sits directly downstream of the 10-phase enable controller.
// - Consumes the one-hot enable bus (enable1..enable10 -> enables_i[0..9]) and checks that exactly
//   one phase fires per cycle, in order 0..NUM_PHASES-1 with wrap-around.
// - Reports lock, frame completion, current phase, classified errors and a saturating error count
//   to the supervisory logic.

---
 rtl/enable_sequence_checker.sv | 136 +++++++++++++
 tb/tb_enable_sequence_checker.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/enable_sequence_checker.sv
// rtl/enable_sequence_checker.sv - one-hot enable sequence checker with lock, error classification and counting
module enable_sequence_checker #(
  parameter int NUM_PHASES  = 10,
  parameter int LOCK_FRAMES = 2,
  parameter int ERR_CNT_W   = 8,
  localparam int PHASE_W    = $clog2(NUM_PHASES)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  clear_i,
  input  logic [NUM_PHASES-1:0] enables_i,
  output logic                  locked_o,
  output logic                  frame_done_o,
  output logic [PHASE_W-1:0]    phase_o,
  output logic                  err_o,
  output logic                  err_missing_o,
  output logic                  err_multi_o,
  output logic                  err_order_o,
  output logic [ERR_CNT_W-1:0]  err_count_o
);

  localparam int GF_W = $clog2(LOCK_FRAMES + 1);
  localparam logic [NUM_PHASES-1:0] ONE_HOT_0 = NUM_PHASES'(1);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);
  localparam logic [GF_W-1:0] LOCK_CNT = GF_W'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t               state_q, state_d;
  logic [PHASE_W-1:0]   expected_q, expected_d;
  logic [GF_W-1:0]      good_q, good_d;
  logic                 locked_q, locked_d;
  logic                 frame_done_q, frame_done_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic                 err_q, err_d;
  logic                 missing_q, missing_d;
  logic                 multi_q, multi_d;
  logic                 order_q, order_d;
  logic [ERR_CNT_W-1:0] count_q, count_d;

  logic is_zero, is_ph0, is_multi, is_match;

  assign is_zero  = (enables_i == '0);
  assign is_ph0   = (enables_i == ONE_HOT_0);
  assign is_multi = ((enables_i & (enables_i - ONE_HOT_0)) != '0);
  assign is_match = (enables_i == (ONE_HOT_0 << expected_q));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= SEARCH;
      expected_q   <= '0;
      good_q       <= '0;
      locked_q     <= 1'b0;
      frame_done_q <= 1'b0;
      phase_q      <= '0;
      err_q        <= 1'b0;
      missing_q    <= 1'b0;
      multi_q      <= 1'b0;
      order_q      <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      expected_q   <= expected_d;
      good_q       <= good_d;
      locked_q     <= locked_d;
      frame_done_q <= frame_done_d;
      phase_q      <= phase_d;
      err_q        <= err_d;
      missing_q    <= missing_d;
      multi_q      <= multi_d;
      order_q      <= order_d;
      count_q      <= count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    expected_d   = expected_q;
    good_d       = good_q;
    locked_d     = locked_q;
    phase_d      = phase_q;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
    // clear lands before any error raised in the same cycle
    missing_d    = clear_i ? 1'b0 : missing_q;
    multi_d      = clear_i ? 1'b0 : multi_q;
    order_d      = clear_i ? 1'b0 : order_q;
    count_d      = clear_i ? '0 : count_q;
    if (state_q == SEARCH) begin
      if (is_ph0) begin
        state_d    = TRACK;
        expected_d = PHASE_W'(1);
        phase_d    = '0;
      end
    end else if (is_match) begin
      phase_d    = expected_q;
      expected_d = (expected_q == LAST_PHASE) ? '0 : expected_q + PHASE_W'(1);
      if (expected_q == LAST_PHASE) begin
        frame_done_d = 1'b1;
        if (good_q != LOCK_CNT) good_d = good_q + GF_W'(1);
        if (state_q == TRACK && good_d == LOCK_CNT) begin
          state_d  = LOCKED;
          locked_d = 1'b1;
        end
      end
    end else begin
      err_d    = 1'b1;
      locked_d = 1'b0;
      good_d   = '0;
      if (count_d != '1) count_d = count_d + ERR_CNT_W'(1);
      if (is_zero)       missing_d = 1'b1;
      else if (is_multi) multi_d   = 1'b1;
      else               order_d   = 1'b1;
      if (is_ph0) begin
        state_d    = TRACK;
        expected_d = PHASE_W'(1);
        phase_d    = '0;
      end else begin
        state_d    = SEARCH;
        expected_d = '0;
      end
    end
  end

  always_comb begin
    locked_o      = locked_q;
    frame_done_o  = frame_done_q;
    phase_o       = phase_q;
    err_o         = err_q;
    err_missing_o = missing_q;
    err_multi_o   = multi_q;
    err_order_o   = order_q;
    err_count_o   = count_q;
  end

endmodule

// File: tb/tb_enable_sequence_checker.sv
// tb/tb_enable_sequence_checker.sv - directed self-checking bench for enable_sequence_checker
module tb_enable_sequence_checker;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       clear_i = 1'b0;
  logic [9:0] enables_i = '0;
  logic       locked_o, frame_done_o, err_o;
  logic       err_missing_o, err_multi_o, err_order_o;
  logic [3:0] phase_o;
  logic [7:0] err_count_o;

  int total = 0;
  int bad = 0;

  enable_sequence_checker dut (
    .clk_i(clk_i), .reset_i(reset_i), .clear_i(clear_i), .enables_i(enables_i),
    .locked_o(locked_o), .frame_done_o(frame_done_o), .phase_o(phase_o),
    .err_o(err_o), .err_missing_o(err_missing_o), .err_multi_o(err_multi_o),
    .err_order_o(err_order_o), .err_count_o(err_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step(input logic [9:0] v, input logic clr);
    enables_i = v;
    clear_i = clr;
    @(posedge clk_i);
    #1;
    clear_i = 1'b0;
  endtask

  task automatic test_reset;
    @(posedge clk_i); #1;
    total++; if ({locked_o, frame_done_o, err_o, err_missing_o, err_multi_o, err_order_o} !== 6'b0)
      begin bad++; $display("FAIL reset_flags got=%b want=000000", {locked_o, frame_done_o, err_o, err_missing_o, err_multi_o, err_order_o}); end
    total++; if (phase_o !== 4'd0 || err_count_o !== 8'd0)
      begin bad++; $display("FAIL reset_values phase=%0d count=%0d want 0/0", phase_o, err_count_o); end
    reset_i = 1'b0;
  endtask

  task automatic test_nominal;
    step(10'h000, 1'b0);
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 10; k++) begin
        step(10'(1 << k), 1'b0);
        total++; if (frame_done_o !== (k == 9))
          begin bad++; $display("FAIL nom_frame_done f=%0d k=%0d got=%b want=%b", f, k, frame_done_o, k == 9); end
        total++; if (locked_o !== (f == 1 && k == 9))
          begin bad++; $display("FAIL nom_locked f=%0d k=%0d got=%b", f, k, locked_o); end
        total++; if (err_o !== 1'b0 || err_count_o !== 8'd0)
          begin bad++; $display("FAIL nom_err f=%0d k=%0d err=%b count=%0d", f, k, err_o, err_count_o); end
      end
    total++; if (phase_o !== 4'd9) begin bad++; $display("FAIL nom_phase got=%0d want=9", phase_o); end
  endtask

  task automatic test_missing;
    for (int k = 0; k < 5; k++) step(10'(1 << k), 1'b0);
    total++; if (phase_o !== 4'd4) begin bad++; $display("FAIL miss_phase_before got=%0d want=4", phase_o); end
    step(10'h000, 1'b0);
    total++; if ({err_o, err_missing_o, err_multi_o, err_order_o, locked_o} !== 5'b11000)
      begin bad++; $display("FAIL miss_flags got=%b want=11000", {err_o, err_missing_o, err_multi_o, err_order_o, locked_o}); end
    total++; if (err_count_o !== 8'd1) begin bad++; $display("FAIL miss_count got=%0d want=1", err_count_o); end
    for (int k = 6; k < 10; k++) begin
      step(10'(1 << k), 1'b0);
      total++; if (err_o !== 1'b0 || frame_done_o !== 1'b0)
        begin bad++; $display("FAIL miss_search_quiet k=%0d err=%b fd=%b", k, err_o, frame_done_o); end
    end
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 10; k++) step(10'(1 << k), 1'b0);
      total++; if (locked_o !== (f == 1))
        begin bad++; $display("FAIL miss_relock f=%0d got=%b want=%b", f, locked_o, f == 1); end
    end
    total++; if (err_count_o !== 8'd1) begin bad++; $display("FAIL miss_count_hold got=%0d want=1", err_count_o); end
  endtask

  task automatic test_multi_order;
    step(10'h001, 1'b1);
    total++; if (err_count_o !== 8'd0 || err_missing_o !== 1'b0 || locked_o !== 1'b1)
      begin bad++; $display("FAIL clear_only count=%0d missing=%b locked=%b want 0/0/1", err_count_o, err_missing_o, locked_o); end
    step(10'h002, 1'b0);
    step(10'h00C, 1'b0);
    total++; if ({err_o, err_missing_o, err_multi_o, err_order_o} !== 4'b1010 || err_count_o !== 8'd1)
      begin bad++; $display("FAIL multi flags=%b count=%0d want 1010/1", {err_o, err_missing_o, err_multi_o, err_order_o}, err_count_o); end
    for (int k = 3; k < 10; k++) step(10'(1 << k), 1'b0);
    for (int k = 0; k < 4; k++) step(10'(1 << k), 1'b0);
    step(10'h008, 1'b0);
    total++; if ({err_o, err_missing_o, err_multi_o, err_order_o} !== 4'b1011 || err_count_o !== 8'd2)
      begin bad++; $display("FAIL order flags=%b count=%0d want 1011/2", {err_o, err_missing_o, err_multi_o, err_order_o}, err_count_o); end
  endtask

  task automatic test_resync;
    for (int k = 0; k < 6; k++) step(10'(1 << k), 1'b0);
    step(10'h001, 1'b0);
    total++; if (err_o !== 1'b1 || err_order_o !== 1'b1 || err_count_o !== 8'd3 || phase_o !== 4'd0)
      begin bad++; $display("FAIL resync err=%b order=%b count=%0d phase=%0d want 1/1/3/0", err_o, err_order_o, err_count_o, phase_o); end
    for (int k = 1; k < 10; k++) begin
      step(10'(1 << k), 1'b0);
      total++; if (frame_done_o !== (k == 9) || err_o !== 1'b0)
        begin bad++; $display("FAIL resync_track k=%0d fd=%b err=%b", k, frame_done_o, err_o); end
    end
  endtask

  task automatic test_saturation;
    step(10'h001, 1'b1);
    for (int i = 0; i < 300; i++) begin
      step(10'h001, 1'b0);
      if (i == 253) begin
        total++; if (err_count_o !== 8'd254) begin bad++; $display("FAIL sat_254 got=%0d want=254", err_count_o); end
      end
    end
    total++; if (err_count_o !== 8'd255 || err_o !== 1'b1)
      begin bad++; $display("FAIL sat_255 count=%0d err=%b want 255/1", err_count_o, err_o); end
    step(10'h000, 1'b1);
    total++; if (err_count_o !== 8'd1 || {err_missing_o, err_multi_o, err_order_o} !== 3'b100)
      begin bad++; $display("FAIL clear_with_err count=%0d flags=%b want 1/100", err_count_o, {err_missing_o, err_multi_o, err_order_o}); end
  endtask

  task automatic test_reset_mid;
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 10; k++) step(10'(1 << k), 1'b0);
    for (int k = 0; k < 4; k++) step(10'(1 << k), 1'b0);
    total++; if (locked_o !== 1'b1 || phase_o !== 4'd3 || err_count_o !== 8'd1)
      begin bad++; $display("FAIL pre_reset locked=%b phase=%0d count=%0d want 1/3/1", locked_o, phase_o, err_count_o); end
    enables_i = 10'h010;
    #2 reset_i = 1'b1;
    #1;
    total++; if ({locked_o, err_missing_o, phase_o, err_count_o} !== 14'd0)
      begin bad++; $display("FAIL async_reset locked=%b missing=%b phase=%0d count=%0d want all 0", locked_o, err_missing_o, phase_o, err_count_o); end
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    for (int k = 5; k < 10; k++) begin
      step(10'(1 << k), 1'b0);
      total++; if (err_o !== 1'b0) begin bad++; $display("FAIL partial_frame k=%0d err=%b want 0", k, err_o); end
    end
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 10; k++) step(10'(1 << k), 1'b0);
      total++; if (locked_o !== (f == 1) || frame_done_o !== 1'b1)
        begin bad++; $display("FAIL reset_relock f=%0d locked=%b fd=%b", f, locked_o, frame_done_o); end
    end
    // back-to-back: phase 0 straight after phase 9 stays clean
    step(10'h001, 1'b0);
    total++; if (err_o !== 1'b0 || locked_o !== 1'b1 || phase_o !== 4'd0)
      begin bad++; $display("FAIL back_to_back err=%b locked=%b phase=%0d", err_o, locked_o, phase_o); end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_missing;
    test_multi_order;
    test_resync;
    test_saturation;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
